// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, DATA_W data bits, optional parity, 1-2 stop bits; idles high.
// Latency: first start-bit clock follows the accept edge; frame takes (1+DATA_W+par+STOP_BITS)*CLKS_PER_BIT clocks.
// Backpressure: tx_ready low for the whole frame; next word is accepted one clock after tx_done at the earliest.
module uart_tx_serializer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              ser_bit,
    output logic              busy,
    output logic              tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        DATA_W < 5 || DATA_W > 10 || CLKS_PER_BIT < 2) begin : g_bad_param
        $error("uart_tx_serializer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BIT_W-1:0]  bit_q;
    logic              stop_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              parity_q;
    logic              ser_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              at_edge;
    logic              head_bit;
    logic              next_bit;

    // The bit on the line is always the head of the shift register, whichever end that is.
    always_comb begin
        shift_d  = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
        head_bit = (LSB_FIRST != 0) ? shift_q[0] : shift_q[DATA_W-1];
        next_bit = (LSB_FIRST != 0) ? shift_d[0] : shift_d[DATA_W-1];
        at_edge  = (cnt_q == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            ser_q    <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) begin
                cnt_q <= at_edge ? '0 : cnt_q + CNT_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (tx_valid) begin
                        shift_q  <= tx_data;
                        parity_q <= (PARITY == 2) ? ~^tx_data : ^tx_data;
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        stop_q   <= 1'b0;
                        ser_q    <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (at_edge) begin
                        ser_q   <= head_bit;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (at_edge) begin
                        if (bit_q == BIT_LAST) begin
                            if (PARITY != 0) begin
                                ser_q   <= parity_q;
                                state_q <= S_PARITY;
                            end else begin
                                ser_q   <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                            shift_q <= shift_d;
                            ser_q   <= next_bit;
                        end
                    end
                end
                S_PARITY: begin
                    if (at_edge) begin
                        ser_q   <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (at_edge) begin
                        if (stop_q == STOP_LAST) begin
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_ready = ready_q;
    assign ser_bit  = ser_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations (8N1, 8E1, 8O1, 10N2 MSB-first) at 4 clocks per bit.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       vld [4];
    logic [9:0] dat [4];
    logic       rdy [4];
    logic       ser [4];
    logic       bsy [4];
    logic       dn  [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          inst;
        logic [9:0]  data;
        logic [15:0] bits;   // frame bit k (k=0 is start) at position k
        int          nbits;
    } vec_t;

    typedef struct {
        int          inst;
        logic [15:0] bits;
        int          nbits;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[10];

    uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .LSB_FIRST(1)) u_8n1 (
        .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(dat[0][7:0]),
        .tx_ready(rdy[0]), .ser_bit(ser[0]), .busy(bsy[0]), .tx_done(dn[0]));
    uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .LSB_FIRST(1)) u_8e1 (
        .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(dat[1][7:0]),
        .tx_ready(rdy[1]), .ser_bit(ser[1]), .busy(bsy[1]), .tx_done(dn[1]));
    uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1), .LSB_FIRST(1)) u_8o1 (
        .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(dat[2][7:0]),
        .tx_ready(rdy[2]), .ser_bit(ser[2]), .busy(bsy[2]), .tx_done(dn[2]));
    uart_tx_serializer #(.DATA_W(10), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2), .LSB_FIRST(0)) u_10n2 (
        .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_data(dat[3]),
        .tx_ready(rdy[3]), .ser_bit(ser[3]), .busy(bsy[3]), .tx_done(dn[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input int inst, input logic [9:0] d, input logic [15:0] bits,
                        input int nbits, input bit push, input bit hold);
        bit   ok = 1'b0;
        logic r;
        exp_t e;
        vld[inst] = 1'b1;
        dat[inst] = d;
        for (int t = 0; t < 100 && !ok; t++) begin
            r = rdy[inst];
            @(posedge clk);
            if (r) ok = 1'b1;
            @(negedge clk);
        end
        if (!hold) vld[inst] = 1'b0;
        if (!ok) begin
            chk($sformatf("accept_timeout i%0d", inst), 32'd0, 32'd1);
        end else if (push) begin
            e.inst  = inst;
            e.bits  = bits;
            e.nbits = nbits;
            sbq.push_back(e);
        end
    endtask

    // Starts at the first cycle after accept; ends in the cycle after completion.
    task automatic run_frame(input int inst);
        exp_t e;
        int   n;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sbq.pop_front();
        n = e.nbits * CPB;
        chk($sformatf("busy_start i%0d", inst), 32'(bsy[inst]), 32'd1);
        chk($sformatf("ready_start i%0d", inst), 32'(rdy[inst]), 32'd0);
        for (int m = 1; m <= n; m++) begin
            chk($sformatf("ser i%0d cyc%0d bit%0d", inst, m, (m - 1) / CPB),
                32'(ser[inst]), 32'(e.bits[(m - 1) / CPB]));
            chk($sformatf("done_early i%0d cyc%0d", inst, m), 32'(dn[inst]), 32'd0);
            @(negedge clk);
        end
        chk($sformatf("done_pulse i%0d", inst), 32'(dn[inst]), 32'd1);
        chk($sformatf("ready_end i%0d", inst), 32'(rdy[inst]), 32'd1);
        chk($sformatf("busy_end i%0d", inst), 32'(bsy[inst]), 32'd0);
        chk($sformatf("ser_idle_end i%0d", inst), 32'(ser[inst]), 32'd1);
    endtask

    initial begin
        vecs[0] = '{0, 10'h0A5, 16'h034A, 10};
        vecs[1] = '{0, 10'h03C, 16'h0278, 10};
        vecs[2] = '{0, 10'h000, 16'h0200, 10};
        vecs[3] = '{0, 10'h0FF, 16'h03FE, 10};
        vecs[4] = '{1, 10'h0A5, 16'h054A, 11};
        vecs[5] = '{1, 10'h001, 16'h0602, 11};
        vecs[6] = '{2, 10'h0A5, 16'h074A, 11};
        vecs[7] = '{2, 10'h003, 16'h0606, 11};
        vecs[8] = '{3, 10'h2C3, 16'h1E1A, 13};
        vecs[9] = '{3, 10'h001, 16'h1C00, 13};

        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0;
            dat[i] = '0;
        end
        rst    = 1'b0;
        vld[0] = 1'b1;
        dat[0] = 10'h0A5;

        // Reset values, with a word offered during reset.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_ser i%0d", i), 32'(ser[i]), 32'd1);
            chk($sformatf("rst_ready i%0d", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("rst_busy i%0d", i), 32'(bsy[i]), 32'd0);
            chk($sformatf("rst_done i%0d", i), 32'(dn[i]), 32'd0);
        end
        @(negedge clk);
        chk("rst_hold_ready", 32'(rdy[0]), 32'd1);
        rst    = 1'b1;
        vld[0] = 1'b0;
        @(negedge clk);
        chk("no_accept_in_reset_ready", 32'(rdy[0]), 32'd1);
        chk("no_accept_in_reset_ser", 32'(ser[0]), 32'd1);

        // Table-driven single frames.
        foreach (vecs[i]) begin
            send(vecs[i].inst, vecs[i].data, vecs[i].bits, vecs[i].nbits, 1'b1, 1'b0);
            run_frame(vecs[i].inst);
            @(negedge clk);
            chk($sformatf("done_one_cycle v%0d", i), 32'(dn[vecs[i].inst]), 32'd0);
        end

        // Back-to-back with tx_valid held; tx_data wiggles mid-frame.
        send(0, 10'h0A5, 16'h034A, 10, 1'b1, 1'b1);
        begin
            exp_t e2;
            e2.inst  = 0;
            e2.bits  = 16'h0278;
            e2.nbits = 10;
            sbq.push_back(e2);
        end
        fork
            run_frame(0);
            begin
                repeat (5) @(negedge clk);
                dat[0] = 10'h0FF;
                repeat (10) @(negedge clk);
                dat[0] = 10'h03C;
            end
        join
        @(negedge clk);
        vld[0] = 1'b0;
        run_frame(0);
        @(negedge clk);

        // Reset pulse at clock 17 of a frame.
        send(0, 10'h0A5, 16'h034A, 10, 1'b0, 1'b0);
        repeat (16) @(negedge clk);
        chk("pre_rst_busy", 32'(bsy[0]), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_ser", 32'(ser[0]), 32'd1);
        chk("mid_rst_ready", 32'(rdy[0]), 32'd1);
        chk("mid_rst_busy", 32'(bsy[0]), 32'd0);
        chk("mid_rst_done", 32'(dn[0]), 32'd0);
        for (int m = 0; m < 40; m++) begin
            @(negedge clk);
            chk($sformatf("post_rst_idle_ser cyc%0d", m), 32'(ser[0]), 32'd1);
            chk($sformatf("post_rst_no_done cyc%0d", m), 32'(dn[0]), 32'd0);
        end
        send(0, 10'h03C, 16'h0278, 10, 1'b1, 1'b0);
        run_frame(0);
        @(negedge clk);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
